// File: rtl/sin_engine_arbiter.sv
// sin_engine_arbiter: round-robin sharing of one sine engine among N_REQ requesters,
// one transaction in flight, with a timeout guarding a missing finish pulse.
module sin_engine_arbiter #(
  parameter int N_REQ     = 4,
  parameter int ID_W      = 2,
  parameter int EN_CYCLES = 2,
  parameter int TIMEOUT   = 31
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_i,
  input  logic [16*N_REQ-1:0]    phase_in_i,
  output logic [N_REQ-1:0]       ack_o,
  output logic                   busy_o,
  output logic                   eng_en_o,
  output logic [15:0]            eng_phase_o,
  input  logic                   eng_finish_i,
  input  logic signed [16:0]     eng_sin_i,
  output logic                   res_valid_o,
  output logic [ID_W-1:0]        res_id_o,
  output logic signed [16:0]     res_sin_o,
  output logic                   res_timeout_o
);
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  state_t             state_q, state_d;
  logic [N_REQ-1:0]   ack_q, ack_d;
  logic               eng_en_q, eng_en_d;
  logic [15:0]        eng_phase_q, eng_phase_d;
  logic [ID_W-1:0]    id_q, id_d, rr_q, rr_d, res_id_q, res_id_d, gnt, idx;
  logic [1:0]         en_cnt_q, en_cnt_d;
  logic [TW-1:0]      timer_q, timer_d;
  logic               res_valid_q, res_valid_d, res_to_q, res_to_d, found, done;
  logic signed [16:0] res_sin_q, res_sin_d;
  // First requesting index after the last one served, wrapping modulo N_REQ.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = ID_W'((int'(rr_q) + k) % N_REQ);
      if (!found && req_i[idx]) begin
        gnt   = idx;
        found = 1'b1;
      end
    end
  end
  always_comb begin
    state_d     = state_q;
    ack_d       = '0;
    eng_en_d    = eng_en_q;
    eng_phase_d = eng_phase_q;
    id_d        = id_q;
    rr_d        = rr_q;
    en_cnt_d    = en_cnt_q;
    timer_d     = timer_q;
    res_valid_d = 1'b0;
    res_id_d    = res_id_q;
    res_sin_d   = res_sin_q;
    res_to_d    = res_to_q;
    done        = eng_finish_i || timer_q == TW'(TIMEOUT);
    case (state_q)
      IDLE: if (found) begin
        ack_d       = N_REQ'(1) << gnt;
        eng_phase_d = phase_in_i[16*gnt +: 16];
        id_d        = gnt;
        rr_d        = gnt;
        eng_en_d    = 1'b1;
        en_cnt_d    = 2'd1;
        state_d     = ISSUE;
      end
      ISSUE: if (en_cnt_q == 2'(EN_CYCLES)) begin
        eng_en_d = 1'b0;
        timer_d  = '0;
        state_d  = WAIT;
      end else begin
        en_cnt_d = en_cnt_q + 2'd1;
      end
      WAIT: begin
        timer_d = timer_q + TW'(1);
        // A finish arriving on the timeout cycle still delivers the engine result.
        if (done) begin
          res_valid_d = 1'b1;
          res_id_d    = id_q;
          res_sin_d   = eng_finish_i ? eng_sin_i : '0;
          res_to_d    = !eng_finish_i;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ack_q       <= '0;
      eng_en_q    <= 1'b0;
      eng_phase_q <= '0;
      id_q        <= '0;
      rr_q        <= ID_W'(N_REQ - 1);
      en_cnt_q    <= '0;
      timer_q     <= '0;
      res_valid_q <= 1'b0;
      res_id_q    <= '0;
      res_sin_q   <= '0;
      res_to_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      ack_q       <= ack_d;
      eng_en_q    <= eng_en_d;
      eng_phase_q <= eng_phase_d;
      id_q        <= id_d;
      rr_q        <= rr_d;
      en_cnt_q    <= en_cnt_d;
      timer_q     <= timer_d;
      res_valid_q <= res_valid_d;
      res_id_q    <= res_id_d;
      res_sin_q   <= res_sin_d;
      res_to_q    <= res_to_d;
    end
  end
  assign ack_o         = ack_q;
  assign busy_o        = state_q != IDLE;
  assign eng_en_o      = eng_en_q;
  assign eng_phase_o   = eng_phase_q;
  assign res_valid_o   = res_valid_q;
  assign res_id_o      = res_id_q;
  assign res_sin_o     = res_sin_q;
  assign res_timeout_o = res_to_q;
endmodule

// File: tb/tb_sin_engine_arbiter.sv
// tb_sin_engine_arbiter: directed and random transactions against a behavioural
// arbiter/engine model; the engine is emulated inline with a configurable finish latency.
module tb_sin_engine_arbiter;
  localparam int N = 4, EN = 2, TO = 31;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [N-1:0] req = '0;
  logic [16*N-1:0] phase = '0;
  logic fin = 1'b0;
  logic signed [16:0] esin = '0;
  logic [N-1:0] ack;
  logic busy, eng_en, res_valid, res_timeout;
  logic [15:0] eng_phase;
  logic [1:0] res_id;
  logic signed [16:0] res_sin;
  int ncmp = 0, nerr = 0, last = N - 1;

  sin_engine_arbiter #(.N_REQ(N), .ID_W(2), .EN_CYCLES(EN), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req_i(req), .phase_in_i(phase), .ack_o(ack), .busy_o(busy),
    .eng_en_o(eng_en), .eng_phase_o(eng_phase), .eng_finish_i(fin), .eng_sin_i(esin),
    .res_valid_o(res_valid), .res_id_o(res_id), .res_sin_o(res_sin), .res_timeout_o(res_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    ncmp++;
    assert (o === e) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Ideal sine at the quadrant points, an arbitrary but fixed value elsewhere.
  function automatic logic signed [16:0] sin_ref(input logic [15:0] p);
    case (p)
      16'd0, 16'd32768: return 17'sd0;
      16'd16384:        return 17'sd32767;
      16'd49152:        return -17'sd32767;
      default:          return $signed({1'b0, p}) - 17'sd32768;
    endcase
  endfunction

  function automatic int pick(input logic [N-1:0] r, input int l);
    for (int k = 1; k <= N; k++)
      if (((r >> ((l + k) % N)) & 4'd1) != 4'd0) return (l + k) % N;
    return -1;
  endfunction

  task automatic all_zero(input string tag);
    chk({tag, "_ack"}, 32'(ack), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_en"}, 32'(eng_en), 0);
    chk({tag, "_phase"}, 32'(eng_phase), 0);
    chk({tag, "_valid"}, 32'(res_valid), 0);
    chk({tag, "_id"}, 32'(res_id), 0);
    chk({tag, "_sin"}, 32'(res_sin), 0);
    chk({tag, "_to"}, 32'(res_timeout), 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    all_zero("reset");
    step();
    rst_n = 1'b1;
    last = N - 1;
  endtask

  task automatic wait_ack(output int g, output logic [15:0] ph);
    int n = 0;
    int e = pick(req, last);
    do begin step(); n++; end while (ack === '0 && n < 50);
    chk("ack_latency", n, 1);
    g  = e;
    ph = phase[16*e +: 16];
    chk("ack_onehot", 32'(ack), 32'(1) << e);
    chk("ack_en", 32'(eng_en), 1);
    chk("ack_phase", 32'(eng_phase), 32'(ph));
    chk("ack_busy", 32'(busy), 1);
    last = e;
  endtask

  // One full transaction; the engine finishes lat cycles after the ack edge (0 = never).
  task automatic serve(input int lat, input bit scramble);
    int g, t_res;
    logic [15:0] ph;
    bit hit;
    wait_ack(g, ph);
    hit   = lat >= EN + 1 && lat <= EN + 1 + TO;
    t_res = hit ? lat : EN + 1 + TO;
    for (int t = 0; t <= t_res; t++) begin
      if (t > 0) begin
        step();
        chk("ack_pulse", 32'(ack), 0);
        chk("en_window", 32'(eng_en), 32'(t < EN));
        chk("phase_hold", 32'(eng_phase), 32'(ph));
        chk("valid_time", 32'(res_valid), 32'(t == t_res));
        chk("busy", 32'(busy), 32'(t < t_res));
      end
      fin  = (t == lat - 1);
      esin = fin ? sin_ref(eng_phase) : 17'($urandom);
      if (t == 1 && scramble) phase[16*g +: 16] = 16'($urandom);
    end
    fin = 1'b0;
    chk("res_id", 32'(res_id), 32'(g));
    chk("res_sin", 32'(res_sin), 32'(hit ? sin_ref(ph) : 17'sd0));
    chk("res_timeout", 32'(res_timeout), 32'(!hit));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    logic [15:0] ph;
    repeat (2) step();
    all_zero("por");
    rst_n = 1'b1;
    // single request, nominal engine
    phase[15:0] = 16'd16384;
    req = 4'b0001;
    serve(20, 1'b0);
    req = '0;
    // all requesters held: rotation 0,1,2,3,0
    do_reset();
    phase = {16'd49152, 16'd32768, 16'd16384, 16'd0};
    req = 4'b1111;
    repeat (5) serve(20, 1'b0);
    req = '0;
    // engine never finishes, then normal service of requester 2
    req = 4'b0001;
    serve(0, 1'b0);
    req = 4'b0100;
    serve(20, 1'b0);
    // edges of the WAIT window: earliest finish, finish on timeout cycle, one too late
    serve(EN + 1, 1'b0);
    serve(EN + 1 + TO, 1'b0);
    serve(EN + 2 + TO, 1'b0);
    req = '0;
    // stray finish in IDLE and in ISSUE
    fin = 1'b1;
    step();
    fin = 1'b0;
    chk("idle_fin_valid", 32'(res_valid), 0);
    chk("idle_fin_busy", 32'(busy), 0);
    step();
    chk("idle_fin_valid2", 32'(res_valid), 0);
    req = 4'b0010;
    serve(1, 1'b0);
    serve(2, 1'b0);
    req = '0;
    // reset in the middle of WAIT for requester 3
    phase[63:48] = 16'd777;
    req = 4'b1000;
    wait_ack(g, ph);
    req = '0;
    repeat (5) step();
    chk("mid_wait_busy", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    all_zero("async_rst");
    step();
    all_zero("rst_held");
    rst_n = 1'b1;
    last = N - 1;
    req = 4'b0110;
    serve(20, 1'b0);
    req = '0;
    // phase changed right after ack must not reach the engine
    req = 4'b0001;
    serve(20, 1'b1);
    req = '0;
    // random traffic
    repeat (25) begin
      for (int i = 0; i < N; i++) phase[16*i +: 16] = 16'($urandom);
      req = 4'($urandom_range(1, 15));
      serve(int'($urandom_range(1, 40)), 1'($urandom_range(0, 1)));
      req = '0;
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
